// File: rtl/bus_arbiter.sv
// Two-master bus arbiter for the MiniRISC data bus with registered exclusive grants,
// combinational bus merge and a sticky hold monitor. Define BUS_ARB_RR_EN for round-robin ties.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_bus_req,
  output logic       m0_bus_grant,
  input  logic [7:0] m0_mst2slv_addr,
  input  logic       m0_mst2slv_wr,
  input  logic       m0_mst2slv_rd,
  input  logic [7:0] m0_mst2slv_data,
  output logic [7:0] m0_slv2mst_data,
  input  logic       m1_bus_req,
  output logic       m1_bus_grant,
  input  logic [7:0] m1_mst2slv_addr,
  input  logic       m1_mst2slv_wr,
  input  logic       m1_mst2slv_rd,
  input  logic [7:0] m1_mst2slv_data,
  output logic [7:0] m1_slv2mst_data,
  output logic [7:0] s_mst2slv_addr,
  output logic       s_mst2slv_wr,
  output logic       s_mst2slv_rd,
  output logic [7:0] s_mst2slv_data,
  input  logic [7:0] s_slv2mst_data,
  output logic       hold_viol
);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       viol_q, viol_d;
  logic       other_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
      viol_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      viol_q  <= viol_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (m0_bus_req && m1_bus_req) begin
`ifdef BUS_ARB_RR_EN
          state_d = last_q ? StGnt0 : StGnt1;
`else
          state_d = StGnt0;
`endif
        end else if (m0_bus_req) begin
          state_d = StGnt0;
        end else if (m1_bus_req) begin
          state_d = StGnt1;
        end
      end
      StGnt0:  if (!m0_bus_req) state_d = m1_bus_req ? StGnt1 : StIdle;
      StGnt1:  if (!m1_bus_req) state_d = m0_bus_req ? StGnt0 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d != state_q) begin
      if (state_d == StGnt0) last_d = 1'b0;
      if (state_d == StGnt1) last_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (state_q != StIdle && cnt_q != 8'hff) begin
      cnt_d = cnt_q + 8'd1;
    end

    other_req = 1'b0;
    if (state_q == StGnt0) other_req = m1_bus_req;
    if (state_q == StGnt1) other_req = m0_bus_req;

    // Judged on the updated count so the flag rises once MAX_HOLD granted cycles have elapsed.
    viol_d = viol_q;
    if (MAX_HOLD != 32'd0 && state_q != StIdle && state_d == state_q &&
        {24'd0, cnt_d} >= MAX_HOLD && other_req) begin
      viol_d = 1'b1;
    end
  end

  always_comb begin
    m0_bus_grant    = (state_q == StGnt0);
    m1_bus_grant    = (state_q == StGnt1);
    hold_viol       = viol_q;
    s_mst2slv_addr  = ({8{m0_bus_grant}} & m0_mst2slv_addr) |
                      ({8{m1_bus_grant}} & m1_mst2slv_addr);
    s_mst2slv_wr    = (m0_bus_grant & m0_mst2slv_wr) | (m1_bus_grant & m1_mst2slv_wr);
    s_mst2slv_rd    = (m0_bus_grant & m0_mst2slv_rd) | (m1_bus_grant & m1_mst2slv_rd);
    s_mst2slv_data  = ({8{m0_bus_grant}} & m0_mst2slv_data) |
                      ({8{m1_bus_grant}} & m1_mst2slv_data);
    m0_slv2mst_data = {8{m0_bus_grant}} & s_slv2mst_data;
    m1_slv2mst_data = {8{m1_bus_grant}} & s_slv2mst_data;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed literal checks plus random traffic
// compared every cycle against an owner/length model.
module tb_bus_arbiter;

  localparam int unsigned Hold = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m0_bus_req = 1'b0, m1_bus_req = 1'b0;
  logic       m0_bus_grant, m1_bus_grant;
  logic [7:0] m0_mst2slv_addr = '0, m1_mst2slv_addr = '0;
  logic       m0_mst2slv_wr = 1'b0, m0_mst2slv_rd = 1'b0;
  logic       m1_mst2slv_wr = 1'b0, m1_mst2slv_rd = 1'b0;
  logic [7:0] m0_mst2slv_data = '0, m1_mst2slv_data = '0;
  logic [7:0] m0_slv2mst_data, m1_slv2mst_data;
  logic [7:0] s_mst2slv_addr, s_mst2slv_data;
  logic       s_mst2slv_wr, s_mst2slv_rd;
  logic [7:0] s_slv2mst_data = '0;
  logic       hold_viol;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  bus_arbiter #(.MAX_HOLD(Hold)) dut (
    .clk(clk), .rst(rst),
    .m0_bus_req(m0_bus_req), .m0_bus_grant(m0_bus_grant),
    .m0_mst2slv_addr(m0_mst2slv_addr), .m0_mst2slv_wr(m0_mst2slv_wr),
    .m0_mst2slv_rd(m0_mst2slv_rd), .m0_mst2slv_data(m0_mst2slv_data),
    .m0_slv2mst_data(m0_slv2mst_data),
    .m1_bus_req(m1_bus_req), .m1_bus_grant(m1_bus_grant),
    .m1_mst2slv_addr(m1_mst2slv_addr), .m1_mst2slv_wr(m1_mst2slv_wr),
    .m1_mst2slv_rd(m1_mst2slv_rd), .m1_mst2slv_data(m1_mst2slv_data),
    .m1_slv2mst_data(m1_slv2mst_data),
    .s_mst2slv_addr(s_mst2slv_addr), .s_mst2slv_wr(s_mst2slv_wr),
    .s_mst2slv_rd(s_mst2slv_rd), .s_mst2slv_data(s_mst2slv_data),
    .s_slv2mst_data(s_slv2mst_data), .hold_viol(hold_viol)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner is 0, 1 or 2 (nobody); len counts completed granted cycles.
  int m_own  = 2;
  int m_last = 1;
  int m_len  = 0;
  bit m_viol = 1'b0;
  int nown, newlen;
  bit stay, other;

  function automatic int pick(input int own, input int last, input bit r0, input bit r1);
    if (own == 2) begin
      if (r0 && r1) begin
`ifdef BUS_ARB_RR_EN
        return (last == 0) ? 1 : 0;
`else
        return 0;
`endif
      end
      if (r0) return 0;
      if (r1) return 1;
      return 2;
    end
    if ((own == 0) ? r0 : r1) return own;
    if ((own == 0) ? r1 : r0) return 1 - own;
    return 2;
  endfunction

  always_comb begin
    nown   = pick(m_own, m_last, m0_bus_req, m1_bus_req);
    stay   = (nown == m_own) && (m_own != 2);
    newlen = stay ? ((m_len >= 255) ? 255 : m_len + 1) : 0;
    other  = (m_own == 0) ? m1_bus_req : (m_own == 1) ? m0_bus_req : 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own  <= 2;
      m_last <= 1;
      m_len  <= 0;
      m_viol <= 1'b0;
    end else begin
      m_own <= nown;
      m_len <= newlen;
      if (nown != m_own && nown != 2) m_last <= nown;
      if (Hold != 0 && stay && newlen >= int'(Hold) && other) m_viol <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      logic [17:0] ebus;
      logic [15:0] eslv;
      ebus = '0;
      eslv = '0;
      if (m_own == 0) begin
        ebus = {m0_mst2slv_addr, m0_mst2slv_wr, m0_mst2slv_rd, m0_mst2slv_data};
        eslv = {s_slv2mst_data, 8'd0};
      end else if (m_own == 1) begin
        ebus = {m1_mst2slv_addr, m1_mst2slv_wr, m1_mst2slv_rd, m1_mst2slv_data};
        eslv = {8'd0, s_slv2mst_data};
      end
      check("grants_viol", {29'd0, m0_bus_grant, m1_bus_grant, hold_viol},
            {29'd0, m_own == 0, m_own == 1, m_viol});
      check("slave_bus", {14'd0, s_mst2slv_addr, s_mst2slv_wr, s_mst2slv_rd, s_mst2slv_data},
            {14'd0, ebus});
      check("read_return", {16'd0, m0_slv2mst_data, m1_slv2mst_data}, {16'd0, eslv});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    m0_bus_req = 1'b0;
    m1_bus_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] tie_exp;
`ifdef BUS_ARB_RR_EN
    tie_exp = 3'b010;
`else
    tie_exp = 3'b000;
`endif
    step();                         // edge 1, reset held
    check_en = 1'b1;
    check("reset_grants", {30'd0, m0_bus_grant, m1_bus_grant}, 32'd0);
    check("reset_viol", {31'd0, hold_viol}, 32'd0);
    rst = 1'b0;

    // Single request: raised after edge 2, granted after edge 3.
    step();
    m0_bus_req = 1'b1; m0_mst2slv_addr = 8'h5A; m0_mst2slv_wr = 1'b1;
    s_slv2mst_data = 8'h77;
    #1 check("no_grant_yet", {31'd0, m0_bus_grant}, 32'd0);
    step();
    check("single_grant", {31'd0, m0_bus_grant}, 32'd1);
    check("single_addr", {24'd0, s_mst2slv_addr}, 32'h5A);
    check("single_wr", {31'd0, s_mst2slv_wr}, 32'd1);
    check("single_m1_rdata", {24'd0, m1_slv2mst_data}, 32'd0);
    check("single_m0_rdata", {24'd0, m0_slv2mst_data}, 32'h77);

    // Handover: m1 waiting, m0 releases.
    m1_bus_req = 1'b1;
    step();
    check("hold_m0", {30'd0, m0_bus_grant, m1_bus_grant}, 32'd2);
    m0_bus_req = 1'b0; m0_mst2slv_wr = 1'b0;
    step();
    check("handover", {30'd0, m0_bus_grant, m1_bus_grant}, 32'd1);
    s_slv2mst_data = 8'hC3;
    #1;
    check("read_m1", {24'd0, m1_slv2mst_data}, 32'hC3);
    check("read_m0", {24'd0, m0_slv2mst_data}, 32'h00);

    // Ties after reset.
    pulse_reset();
    for (int k = 0; k < 3; k++) begin
      m0_bus_req = 1'b1; m1_bus_req = 1'b1;
      step();
      check($sformatf("tie_%0d", k), {30'd0, m0_bus_grant, m1_bus_grant},
            tie_exp[k] ? 32'd1 : 32'd2);
      m0_bus_req = 1'b0; m1_bus_req = 1'b0;
      step();
    end

    // Hold monitor with MAX_HOLD = 4.
    pulse_reset();
    m0_bus_req = 1'b1; m1_bus_req = 1'b1;
    step();
    check("hold_grant", {31'd0, m0_bus_grant}, 32'd1);
    repeat (3) step();
    check("hold_viol_3", {31'd0, hold_viol}, 32'd0);
    step();
    check("hold_viol_4", {30'd0, hold_viol, m0_bus_grant}, 32'd3);
    repeat (6) step();
    m0_bus_req = 1'b0;
    step();
    check("hold_after", {29'd0, m0_bus_grant, m1_bus_grant, hold_viol}, 32'd3);

    // Async reset mid-grant on m1.
    m1_mst2slv_addr = 8'hAA; m1_mst2slv_wr = 1'b1; m1_mst2slv_rd = 1'b1;
    m1_mst2slv_data = 8'h55;
    #1 check("pre_rst_addr", {24'd0, s_mst2slv_addr}, 32'hAA);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_grant", {31'd0, m1_bus_grant}, 32'd0);
    check("async_bus", {14'd0, s_mst2slv_addr, s_mst2slv_wr, s_mst2slv_rd, s_mst2slv_data},
          32'd0);
    check("async_viol", {31'd0, hold_viol}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    m1_bus_req = 1'b0; m0_bus_req = 1'b1;
    step();
    check("post_rst_grant", {30'd0, m0_bus_grant, m1_bus_grant}, 32'd2);

    // Random traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 3) == 0) m0_bus_req = ~m0_bus_req;
      if ($urandom_range(0, 3) == 0) m1_bus_req = ~m1_bus_req;
      m0_mst2slv_addr = 8'($urandom); m0_mst2slv_data = 8'($urandom);
      m1_mst2slv_addr = 8'($urandom); m1_mst2slv_data = 8'($urandom);
      {m0_mst2slv_wr, m0_mst2slv_rd, m1_mst2slv_wr, m1_mst2slv_rd} = 4'($urandom);
      s_slv2mst_data = 8'($urandom);
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
